// File: rtl/flashmem_emulator.sv
// FM-interface flash macro stand-in: 64-word page buffer in front of a 16-bit word array.
// Define FLASHMEM_EMULATOR_WEAR_COUNT_EN to add 8-bit saturating per-page program counters.
//
// state     | meaning
// IDLE      | waiting for a PROGRAM/WEN/REN strobe
// LOAD      | copying the addressed array page into the buffer, one word per cycle
// ACCESS    | latency countdown; completes read, write, page status or a 1-cycle reject
// PROG      | copying the buffer back into its array page, one word per cycle
// PROG_WAIT | post-copy program time
module flashmem_emulator #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2,
  parameter int PROG_LAT = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [16:0] FM_ADDR,
  input  logic [15:0] FM_WD,
  input  logic        FM_REN,
  input  logic        FM_WEN,
  input  logic        FM_PROGRAM,
  input  logic        FM_PAGESTATUS,
  output logic [15:0] FM_RD,
  output logic        FM_BUSY,
  output logic [1:0]  FM_STATUS
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NPAGES = 1 << (ADDR_W - 6);
  localparam int PG_W   = ADDR_W - 6;
  localparam int MAXLAT = (READ_LAT > PROG_LAT) ? READ_LAT : PROG_LAT;
  localparam int LAT_W  = (MAXLAT < 2) ? 1 : $clog2(MAXLAT + 1);

  localparam logic [LAT_W-1:0] RD_INIT  = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] PW_INIT  = LAT_W'((PROG_LAT > 0) ? PROG_LAT - 1 : 0);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [17:0]      ADDR_LIM = 18'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, ACCESS, PROG, PROG_WAIT} state_t;
  typedef enum logic [1:0] {OP_READ, OP_PSTAT, OP_WRITE, OP_FIN} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [1:0]        res_q, res_d;

  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wd_q;
  logic              buf_valid_q, buf_dirty_q;
  logic [PG_W-1:0]   buf_page_q;
  logic [15:0]       rd_q;
  logic [1:0]        status_q;

  // Array contents survive wb_rst_i; the declaration initialiser gives the erased state.
  logic [15:0]       arr_mem [0:DEPTH-1] = '{default: 16'hFFFF};
  logic [15:0]       buf_mem [0:63];

  logic              any_strobe, out_range;
  logic [PG_W-1:0]   in_page, page_q;
  logic [5:0]        off_q;
  logic              accept, load_we, prog_we, set_buf, fin_access, fin_prog;
  logic              buf_hit;
  logic [15:0]       rd_word, pstat_word;
  logic [7:0]        wear_rd;

  assign any_strobe = FM_PROGRAM | FM_WEN | FM_REN;
  assign out_range  = {1'b0, FM_ADDR} >= ADDR_LIM;
  assign in_page    = FM_ADDR[ADDR_W-1:6];
  assign page_q     = addr_q[ADDR_W-1:6];
  assign off_q      = addr_q[5:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    res_d      = res_q;
    accept     = 1'b0;
    load_we    = 1'b0;
    prog_we    = 1'b0;
    set_buf    = 1'b0;
    fin_access = 1'b0;
    fin_prog   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_strobe) begin
          accept  = 1'b1;
          state_d = ACCESS;
          cnt_d   = RD_INIT;
          wcnt_d  = 6'd0;
          res_d   = 2'b00;
          if (out_range) begin
            op_d  = OP_FIN;
            res_d = 2'b11;
            cnt_d = '0;
          end else if (FM_PROGRAM) begin
            op_d  = OP_FIN;
            cnt_d = '0;
            if (!buf_dirty_q) begin
              res_d = 2'b00;
            end else if (buf_page_q != in_page) begin
              res_d = 2'b01;
            end else begin
              state_d = PROG;
            end
          end else if (FM_WEN) begin
            op_d = OP_WRITE;
            if (buf_valid_q && buf_page_q == in_page) begin
              state_d = ACCESS;
            end else if (buf_dirty_q) begin
              op_d  = OP_FIN;
              res_d = 2'b01;
              cnt_d = '0;
            end else begin
              state_d = LOAD;
            end
          end else begin
            op_d = FM_PAGESTATUS ? OP_PSTAT : OP_READ;
          end
        end
      end
      LOAD: begin
        load_we = 1'b1;
        wcnt_d  = wcnt_q + 6'd1;
        if (wcnt_q == 6'd63) begin
          set_buf = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          fin_access = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_ONE;
        end
      end
      PROG: begin
        prog_we = 1'b1;
        wcnt_d  = wcnt_q + 6'd1;
        if (wcnt_q == 6'd63) begin
          if (PROG_LAT == 0) begin
            fin_prog = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d   = PW_INIT;
            state_d = PROG_WAIT;
          end
        end
      end
      PROG_WAIT: begin
        if (cnt_q == '0) begin
          fin_prog = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_FIN;
      cnt_q   <= '0;
      wcnt_q  <= 6'd0;
      res_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
    end
  end

  assign buf_hit    = buf_valid_q && (buf_page_q == page_q);
  assign rd_word    = buf_hit ? buf_mem[off_q] : arr_mem[addr_q];
  assign pstat_word = {wear_rd, 6'b0, buf_hit, buf_dirty_q && (buf_page_q == page_q)};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr_q      <= '0;
      wd_q        <= 16'h0000;
      buf_valid_q <= 1'b0;
      buf_dirty_q <= 1'b0;
      buf_page_q  <= '0;
      rd_q        <= 16'h0000;
      status_q    <= 2'b00;
    end else begin
      if (accept) begin
        addr_q <= FM_ADDR[ADDR_W-1:0];
        wd_q   <= FM_WD;
      end
      if (set_buf) begin
        buf_valid_q <= 1'b1;
        buf_page_q  <= page_q;
      end
      if (fin_access) begin
        status_q <= res_q;
        case (op_q)
          OP_READ:  rd_q <= rd_word;
          OP_PSTAT: rd_q <= pstat_word;
          OP_WRITE: buf_dirty_q <= 1'b1;
          default:  ;
        endcase
      end
      if (fin_prog) begin
        buf_dirty_q <= 1'b0;
        status_q    <= 2'b00;
      end
    end
  end

  // Copies are gated by reset so an aborted PROG stops before the word in flight.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (load_we) begin
        buf_mem[wcnt_q] <= arr_mem[{page_q, wcnt_q}];
      end else if (fin_access && op_q == OP_WRITE) begin
        buf_mem[off_q] <= wd_q;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && prog_we) begin
      arr_mem[{buf_page_q, wcnt_q}] <= buf_mem[wcnt_q];
    end
  end

`ifdef FLASHMEM_EMULATOR_WEAR_COUNT_EN
  logic [7:0] wear_q [0:NPAGES-1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NPAGES; i++) wear_q[i] <= 8'h00;
    end else if (fin_prog && wear_q[buf_page_q] != 8'hFF) begin
      wear_q[buf_page_q] <= wear_q[buf_page_q] + 8'h01;
    end
  end

  assign wear_rd = wear_q[page_q];
`else
  assign wear_rd = 8'h00;
`endif

  assign FM_BUSY   = (state_q != IDLE);
  assign FM_RD     = rd_q;
  assign FM_STATUS = status_q;

endmodule
